// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for serial_add_ctrl.
// The sub line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;

  modport master (output start, a, b, sub, input busy, done, sum, co);
  modport slave  (input start, a, b, sub, output busy, done, sum, co);
`else
  modport master (output start, a, b, input busy, done, sum, co);
  modport slave  (input start, a, b, output busy, done, sum, co);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder (LSB first, one shared full adder) with IDLE/RUN/DONE control.
// Optional subtract mode when SERIAL_ADD_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; sum/co hold the last result
// RUN   | one bit per cycle for WIDTH cycles
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_in;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Full adder as two half-adder stages.
  logic hs1, hc1, fa_s, hc2, fa_co;
  assign hs1   = a_q[0] ^ b_q[0];
  assign hc1   = a_q[0] & b_q[0];
  assign fa_s  = hs1 ^ carry_q;
  assign hc2   = hs1 & carry_q;
  assign fa_co = hc1 | hc2;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{sub_in}};
          carry_d = sub_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          sum_d   = res_d;
          co_d    = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
endmodule
